// File: rtl/cu_vertex_cache_read_requester_module.sv
// Vertex read requester: one 128B line read per vertex index, command at N+1, output at last-event+1.
// Backpressure via request_ready_out (all slots busy or disabled); CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN adds error_count_out.
package cu_vertex_read_pkg;
  localparam logic [1:0] RESP_DONE   = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd1;

  typedef struct packed {
    logic        valid;
    logic [63:0] address;
    logic [7:0]  size;
    logic [7:0]  tag;
  } CommandBufferLine;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [1:0] code;
  } ResponseBufferLine;

  typedef struct packed {
    logic         valid;
    logic [7:0]   tag;
    logic [511:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id_x;
    logic [7:0]  cu_id_y;
    logic [31:0] data;
  } EdgeDataRead;

  function automatic logic [31:0] swap_endianness_data_read(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

module cu_vertex_cache_read_requester_module
  import cu_vertex_read_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int DATA_W          = 32
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  logic [63:0]       array_base_address_in,
  input  logic              request_valid_in,
  input  logic [31:0]       request_index_in,
  input  logic [15:0]       request_cu_id_in,
  output logic              request_ready_out,
  output CommandBufferLine  read_command_out,
  input  ResponseBufferLine read_response_in,
  input  ReadWriteDataLine  read_data_0_in,
  input  ReadWriteDataLine  read_data_1_in,
  output EdgeDataRead       edge_data_variable_out
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
  ,
  output logic [31:0]       error_count_out
`endif
);

  localparam int N     = MAX_OUTSTANDING;
  localparam int TAG_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     busy_q, busy_d, d0_q, d0_d, d1_q, d1_d, rsp_q, rsp_d;
  logic [4:0]       off_q  [N];
  logic [4:0]       off_d  [N];
  logic [15:0]      cuid_q [N];
  logic [15:0]      cuid_d [N];
  logic [31:0]      word_q [N];
  logic [31:0]      word_d [N];
  CommandBufferLine cmd_q, cmd_d;
  logic [1:0]       rdy_en_q, rdy_en_d;

  logic [63:0]      byte_addr;
  logic             free_vld, done_vld, accept;
  logic [TAG_W-1:0] free_idx, done_idx, d0_idx, d1_idx, rsp_idx;
  logic             d0_hit, d1_hit, rsp_hit;
  logic [N-1:0]     complete;

  assign byte_addr = array_base_address_in + 64'(request_index_in) * 64'(DATA_W / 8);
  assign complete  = busy_q & d0_q & d1_q & rsp_q;

  // Tags beyond the slot range or on idle slots are stale and dropped.
  assign d0_idx  = read_data_0_in.tag[TAG_W-1:0];
  assign d1_idx  = read_data_1_in.tag[TAG_W-1:0];
  assign rsp_idx = read_response_in.tag[TAG_W-1:0];
  assign d0_hit  = read_data_0_in.valid && (int'(read_data_0_in.tag) < N) && busy_q[d0_idx];
  assign d1_hit  = read_data_1_in.valid && (int'(read_data_1_in.tag) < N) && busy_q[d1_idx];
  assign rsp_hit = read_response_in.valid && (int'(read_response_in.tag) < N) && busy_q[rsp_idx];

  logic unused_addr_lo;
  assign unused_addr_lo = ^byte_addr[1:0];

`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
  logic [31:0] err_q, err_d;
  assign error_count_out = err_q;
`else
  logic unused_resp_code;
  assign unused_resp_code = ^read_response_in.code;
`endif

  always_comb begin
    busy_d   = busy_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    rsp_d    = rsp_q;
    off_d    = off_q;
    cuid_d   = cuid_q;
    word_d   = word_q;
    cmd_d    = '0;
    rdy_en_d = {rdy_en_q[0], 1'b1};
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
    err_d    = err_q;
`endif
    free_vld = 1'b0;
    free_idx = '0;
    done_vld = 1'b0;
    done_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = TAG_W'(i);
      end
      if (complete[i]) begin
        done_vld = 1'b1;
        done_idx = TAG_W'(i);
      end
    end

    request_ready_out = rdy_en_q[1] & enabled_in & free_vld;
    accept            = request_valid_in & request_ready_out;

    // Only the word the slot will emit is kept, chosen by its offset.
    if (d0_hit) begin
      d0_d[d0_idx] = 1'b1;
      if (!off_q[d0_idx][4])
        word_d[d0_idx] = read_data_0_in.data[{off_q[d0_idx][3:0], 5'b0} +: 32];
    end
    if (d1_hit) begin
      d1_d[d1_idx] = 1'b1;
      if (off_q[d1_idx][4])
        word_d[d1_idx] = read_data_1_in.data[{off_q[d1_idx][3:0], 5'b0} +: 32];
    end
    if (rsp_hit) begin
      rsp_d[rsp_idx] = 1'b1;
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
      if (read_response_in.code != RESP_DONE) begin
        busy_d[rsp_idx] = 1'b0;
        if (err_q != '1)
          err_d = err_q + 32'd1;
      end
`endif
    end

    if (done_vld)
      busy_d[done_idx] = 1'b0;

    if (accept) begin
      busy_d[free_idx] = 1'b1;
      d0_d[free_idx]   = 1'b0;
      d1_d[free_idx]   = 1'b0;
      rsp_d[free_idx]  = 1'b0;
      off_d[free_idx]  = byte_addr[6:2];
      cuid_d[free_idx] = request_cu_id_in;
      cmd_d.valid      = 1'b1;
      cmd_d.address    = {byte_addr[63:7], 7'b0};
      cmd_d.size       = 8'd128;
      cmd_d.tag        = 8'(free_idx);
    end

    read_command_out       = cmd_q;
    edge_data_variable_out = '0;
    if (done_vld) begin
      edge_data_variable_out.valid   = 1'b1;
      edge_data_variable_out.cu_id_x = cuid_q[done_idx][15:8];
      edge_data_variable_out.cu_id_y = cuid_q[done_idx][7:0];
      edge_data_variable_out.data    = swap_endianness_data_read(word_q[done_idx]);
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn_in) begin
      busy_q   <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      rsp_q    <= '0;
      cmd_q    <= '0;
      rdy_en_q <= '0;
      for (int i = 0; i < N; i++) begin
        off_q[i]  <= '0;
        cuid_q[i] <= '0;
        word_q[i] <= '0;
      end
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
      err_q    <= '0;
`endif
    end else begin
      busy_q   <= busy_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      rsp_q    <= rsp_d;
      cmd_q    <= cmd_d;
      rdy_en_q <= rdy_en_d;
      off_q    <= off_d;
      cuid_q   <= cuid_d;
      word_q   <= word_d;
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cu_vertex_cache_read_requester_module.sv
// Bench for the vertex read requester: slot-level reference model plus directed scenarios with literal expectations.
module tb_cu_vertex_cache_read_requester_module;
  import cu_vertex_read_pkg::*;

  localparam int N = 8;

  logic              clock = 1'b0;
  logic              rstn_in;
  logic              enabled_in;
  logic [63:0]       array_base_address_in;
  logic              request_valid_in;
  logic [31:0]       request_index_in;
  logic [15:0]       request_cu_id_in;
  logic              request_ready_out;
  CommandBufferLine  read_command_out;
  ResponseBufferLine read_response_in;
  ReadWriteDataLine  read_data_0_in;
  ReadWriteDataLine  read_data_1_in;
  EdgeDataRead       edge_data_variable_out;
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
  logic [31:0]       error_count_out;
`endif

  always #5 clock = ~clock;

  cu_vertex_cache_read_requester_module #(.MAX_OUTSTANDING(N), .DATA_W(32)) dut (
    .clock                  (clock),
    .rstn_in                (rstn_in),
    .enabled_in             (enabled_in),
    .array_base_address_in  (array_base_address_in),
    .request_valid_in       (request_valid_in),
    .request_index_in       (request_index_in),
    .request_cu_id_in       (request_cu_id_in),
    .request_ready_out      (request_ready_out),
    .read_command_out       (read_command_out),
    .read_response_in       (read_response_in),
    .read_data_0_in         (read_data_0_in),
    .read_data_1_in         (read_data_1_in),
    .edge_data_variable_out (edge_data_variable_out)
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
    ,
    .error_count_out        (error_count_out)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int          cyc;
    logic [15:0] cuid;
    logic [31:0] data;
  } out_rec_t;
  out_rec_t         out_log[$];
  CommandBufferLine cmd_log[$];
  int               cmd_cyc[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: a slot table holding full byte addresses and whole line halves.
  logic [N-1:0]     m_busy, m_f0, m_f1, m_fr;
  logic [63:0]      m_addr [N];
  logic [15:0]      m_cuid [N];
  logic [511:0]     m_h0   [N];
  logic [511:0]     m_h1   [N];
  int               m_rdy_cnt;
  CommandBufferLine m_cmd;
  logic [31:0]      m_err;

  function automatic bit m_ready();
    int nfree;
    nfree = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) nfree++;
    return (m_rdy_cnt >= 2) && (enabled_in === 1'b1) && (nfree > 0);
  endfunction

  function automatic int m_out_tag();
    for (int i = 0; i < N; i++)
      if (m_busy[i] && m_f0[i] && m_f1[i] && m_fr[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_word(input int t);
    int           off;
    logic [511:0] h;
    logic [31:0]  w, r;
    off = int'(m_addr[t] - (m_addr[t] & ~64'h7F));
    h   = (off < 64) ? m_h0[t] : m_h1[t];
    w   = h[(off % 64) * 8 +: 32];
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] pre;
    int ot, ft, t;
    bit acc;
    if (rstn_in !== 1'b1) begin
      m_busy = '0; m_f0 = '0; m_f1 = '0; m_fr = '0;
      m_rdy_cnt = 0; m_cmd = '0; m_err = '0;
      return;
    end
    pre = m_busy;
    ot  = m_out_tag();
    acc = (request_valid_in === 1'b1) && m_ready();
    ft  = -1;
    for (int i = N - 1; i >= 0; i--) if (!pre[i]) ft = i;
    t = int'(read_data_0_in.tag);
    if (read_data_0_in.valid && t < N && pre[t]) begin m_f0[t] = 1'b1; m_h0[t] = read_data_0_in.data; end
    t = int'(read_data_1_in.tag);
    if (read_data_1_in.valid && t < N && pre[t]) begin m_f1[t] = 1'b1; m_h1[t] = read_data_1_in.data; end
    t = int'(read_response_in.tag);
    if (read_response_in.valid && t < N && pre[t]) begin
      m_fr[t] = 1'b1;
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
      if (read_response_in.code != RESP_DONE) begin
        m_busy[t] = 1'b0;
        if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
      end
`endif
    end
    if (ot >= 0) m_busy[ot] = 1'b0;
    m_cmd = '0;
    if (acc) begin
      m_busy[ft] = 1'b1;
      m_f0[ft] = 1'b0; m_f1[ft] = 1'b0; m_fr[ft] = 1'b0;
      m_addr[ft] = array_base_address_in + 64'(request_index_in) * 64'd4;
      m_cuid[ft] = request_cu_id_in;
      m_cmd = '{valid: 1'b1, address: m_addr[ft] & ~64'h7F, size: 8'd128, tag: 8'(ft)};
    end
    if (m_rdy_cnt < 2) m_rdy_cnt++;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    model_step();
  end

  // Compare process: every cycle, shortly after the clock edge.
  initial forever begin
    int          t;
    EdgeDataRead e;
    @(posedge clock);
    #1;
    if (chk_on) begin
      t = m_out_tag();
      e = '0;
      if (t >= 0) begin
        e.valid   = 1'b1;
        e.cu_id_x = m_cuid[t][15:8];
        e.cu_id_y = m_cuid[t][7:0];
        e.data    = m_word(t);
      end
      chk("cmd", 128'(read_command_out), 128'(m_cmd));
      chk("ready", 128'(request_ready_out), 128'(m_ready()));
      chk("edge_out", 128'(edge_data_variable_out), 128'(e));
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
      chk("err_count", 128'(error_count_out), 128'(m_err));
`endif
      if (edge_data_variable_out.valid === 1'b1)
        out_log.push_back('{cyc, {edge_data_variable_out.cu_id_x, edge_data_variable_out.cu_id_y},
                            edge_data_variable_out.data});
      if (read_command_out.valid === 1'b1) begin
        cmd_log.push_back(read_command_out);
        cmd_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clock);
    request_valid_in = 1'b0;
    read_data_0_in   = '0;
    read_data_1_in   = '0;
    read_response_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [511:0] half(input int h, input int k, input logic [31:0] v);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = 32'hC0DE_0000 | 32'(h * 256 + j);
    r[k*32 +: 32] = v;
    return r;
  endfunction

  task automatic req(input int idx, input logic [15:0] cuid);
    request_valid_in = 1'b1;
    request_index_in = 32'(idx);
    request_cu_id_in = cuid;
  endtask

  task automatic set_d0(input int t, input logic [511:0] d);
    read_data_0_in = '{valid: 1'b1, tag: 8'(t), data: d};
  endtask

  task automatic set_d1(input int t, input logic [511:0] d);
    read_data_1_in = '{valid: 1'b1, tag: 8'(t), data: d};
  endtask

  task automatic set_rsp(input int t, input logic [1:0] code);
    read_response_in = '{valid: 1'b1, tag: 8'(t), code: code};
  endtask

  task automatic complete(input int t);
    set_d0(t, half(0, 0, 32'hC0DE_0000));
    set_d1(t, half(1, 0, 32'hC0DE_0100));
    set_rsp(t, RESP_DONE);
    step();
  endtask

  task automatic expect_out(input int k, input int ecyc, input logic [15:0] cuid, input logic [31:0] d);
    if (out_log.size() <= k) begin
      checks++; errors++;
      $display("FAIL out_missing: output #%0d absent, only %0d outputs seen", k, out_log.size());
    end else begin
      chk($sformatf("out%0d_cycle", k), 128'(out_log[k].cyc), 128'(ecyc));
      chk($sformatf("out%0d_cuid", k), 128'(out_log[k].cuid), 128'(cuid));
      chk($sformatf("out%0d_data", k), 128'(out_log[k].data), 128'(d));
    end
  endtask

  task automatic expect_cmd(input int k, input logic [63:0] addr, input int tag);
    if (cmd_log.size() <= k) begin
      checks++; errors++;
      $display("FAIL cmd_missing: command #%0d absent, only %0d commands seen", k, cmd_log.size());
    end else begin
      chk($sformatf("cmd%0d_addr", k), 128'(cmd_log[k].address), 128'(addr));
      chk($sformatf("cmd%0d_tag", k), 128'(cmd_log[k].tag), 128'(tag));
      chk($sformatf("cmd%0d_size", k), 128'(cmd_log[k].size), 128'(128));
    end
  endtask

  initial begin
    int c;
    rstn_in = 1'b0; enabled_in = 1'b1; array_base_address_in = 64'h1000;
    request_valid_in = 1'b0; request_index_in = '0; request_cu_id_in = '0;
    read_response_in = '0; read_data_0_in = '0; read_data_1_in = '0;
    repeat (3) @(negedge clock);
    chk_on  = 1'b1;
    rstn_in = 1'b1;
    step();
    chk("ready_after_1st_edge", 128'(request_ready_out), 128'(0));
    chk("out_valid_after_reset", 128'(edge_data_variable_out.valid), 128'(0));
    step();
    chk("ready_after_2nd_edge", 128'(request_ready_out), 128'(1));

    // Base 0x1000, index 5: word 5 of half 0.
    req(5, 16'h0102); c = cyc; step();
    expect_cmd(0, 64'h1000, 0);
    chk("cmd0_cycle", 128'(cmd_cyc[0]), 128'(c + 1));
    set_d0(0, half(0, 5, 32'h1122_3344)); set_d1(0, half(1, 0, 32'h0)); set_rsp(0, RESP_DONE);
    c = cyc; step();
    expect_out(0, c + 1, 16'h0102, 32'h4433_2211);
    idle(1);

    // Index 40 sits at word 8 of line 0x1080; index 20 at word 4 of half 1.
    req(40, 16'h0304); step();
    expect_cmd(1, 64'h1080, 0);
    set_d0(0, half(0, 8, 32'hAABB_CCDD)); set_d1(0, half(1, 8, 32'h5566_7788)); set_rsp(0, RESP_DONE);
    c = cyc; step();
    expect_out(1, c + 1, 16'h0304, 32'hDDCC_BBAA);
    idle(1);
    req(20, 16'h0506); step();
    expect_cmd(2, 64'h1000, 0);
    set_d0(0, half(0, 4, 32'h9999_9999)); set_d1(0, half(1, 4, 32'h0102_0304)); set_rsp(0, RESP_DONE);
    c = cyc; step();
    expect_out(2, c + 1, 16'h0506, 32'h0403_0201);
    idle(1);

    // Fill all eight slots, then free tag 3.
    for (int i = 0; i < 8; i++) begin req(i, 16'h1000 + 16'(i)); step(); end
    chk("ready_full", 128'(request_ready_out), 128'(0));
    chk("cmd10_tag", 128'(cmd_log.size() > 10 ? cmd_log[10].tag : 8'hFF), 128'(7));
    req(9, 16'h1009); step();
    complete_t3: begin
      c = cyc; complete(3);
      expect_out(3, c + 1, 16'h1003, 32'h0300_DEC0);
      chk("ready_in_output_cycle", 128'(request_ready_out), 128'(0));
      step();
      chk("ready_after_output", 128'(request_ready_out), 128'(1));
    end

    // Tags 2 and 6 complete in the same cycle.
    set_d0(2, half(0, 0, 32'hC0DE_0000)); set_rsp(2, RESP_DONE); set_d1(6, half(1, 0, 32'hC0DE_0100)); step();
    set_rsp(6, RESP_DONE); step();
    set_d1(2, half(1, 0, 32'hC0DE_0100)); set_d0(6, half(0, 0, 32'hC0DE_0000));
    c = cyc; step(); step();
    expect_out(4, c + 1, 16'h1002, 32'h0200_DEC0);
    expect_out(5, c + 2, 16'h1006, 32'h0600_DEC0);
    complete(0); complete(1); complete(4); complete(5); complete(7);
    idle(2);

    // Disabled: in-flight request finishes, new request dropped; stray tag 5 ignored.
    req(3, 16'h2021); step();
    enabled_in = 1'b0;
    set_rsp(0, RESP_DONE); step();
    chk("ready_disabled", 128'(request_ready_out), 128'(0));
    set_d0(0, half(0, 0, 32'hC0DE_0000)); req(7, 16'h2222); step();
    set_d1(0, half(1, 0, 32'hC0DE_0100)); c = cyc; step();
    expect_out(11, c + 1, 16'h2021, 32'h0300_DEC0);
    chk("dropped_cmd_count", 128'(cmd_log.size()), 128'(12));
    set_rsp(5, RESP_DONE); set_d0(5, half(0, 0, 32'h0)); set_d1(5, half(1, 0, 32'h0)); step();
    idle(2);
    chk("stray_no_output", 128'(out_log.size()), 128'(12));
    enabled_in = 1'b1;
    idle(2);

    // Reset with four in flight; late traffic for them must vanish.
    for (int i = 0; i < 4; i++) begin req(i, 16'h3000 + 16'(i)); step(); end
    set_d0(0, half(0, 0, 32'h0)); set_rsp(1, RESP_DONE); step();
    rstn_in = 1'b0; step();
    rstn_in = 1'b1;
    for (int i = 0; i < 4; i++) complete(i);
    idle(2);
    chk("late_no_output", 128'(out_log.size()), 128'(12));
    req(9, 16'h4444); step();
    expect_cmd(16, 64'h1000, 0);
    c = cyc; complete(0);
    expect_out(12, c + 1, 16'h4444, 32'h0900_DEC0);
    idle(1);

    // Failed response code.
    req(2, 16'h5555); step();
    set_d0(0, half(0, 0, 32'hC0DE_0000)); set_d1(0, half(1, 0, 32'hC0DE_0100)); set_rsp(0, RESP_FAILED);
    step(); idle(2);
`ifdef CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN
    chk("failed_err_count", 128'(error_count_out), 128'(1));
    chk("failed_no_output", 128'(out_log.size()), 128'(13));
`else
    chk("failed_as_done", 128'(out_log.size()), 128'(14));
`endif
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_vertex_cache_read_requester_module.md
CU_VERTEX_CACHE_READ_REQUESTER_MODULE -- requirements
Module: cu_vertex_cache_read_requester_module

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, giving the number of tracking slots; the tag equals the slot index.
REQ-002 SHALL have parameter DATA_W, default 32, giving the vertex data width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port rstn_in, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port enabled_in, input, 1, the request-acceptance enable.
REQ-006 SHALL have port array_base_address_in, input, 64, the vertex array byte base address, 128B aligned.
REQ-007 SHALL have port request_valid_in, input, 1, the request strobe.
REQ-008 SHALL have port request_index_in, input, 32, the vertex index.
REQ-009 SHALL have port request_cu_id_in, input, 16, {cu_id_x, cu_id_y} returned with the data.
REQ-010 SHALL have port request_ready_out, output, 1, high when a free slot exists and enabled is high.
REQ-011 SHALL have port read_command_out, output, CommandBufferLine, the cacheline read command; payload tag = slot.
REQ-012 SHALL have port read_response_in, input, ResponseBufferLine, the response carrying tag and response code.
REQ-013 SHALL have port read_data_0_in, input, ReadWriteDataLine, holding line bytes 0-63 and a tag.
REQ-014 SHALL have port read_data_1_in, input, ReadWriteDataLine, holding line bytes 64-127 and a tag.
REQ-015 SHALL have port edge_data_variable_out, output, EdgeDataRead, the extracted vertex word with cu_id_x/y.

Function
REQ-016 SHALL accept a request in a cycle where request_valid_in and request_ready_out are both high; requests with request_ready_out low are dropped (the upstream block guarantees this does not happen).
REQ-017 SHALL compute byte address = base + index*(DATA_W/8), line address = address with bits [6:0] cleared, and word offset = address[6:2].
REQ-018 SHALL allocate the lowest-index free slot and store the offset and cu_id in it.
REQ-019 SHALL assert read_command_out.valid for exactly one cycle, in cycle N+1 after acceptance in cycle N, carrying the line address, tag and size 128.
REQ-020 SHALL record, per busy slot, three arrival flags: data_0 (saving the 512b half), data_1 (saving the half), and response.
REQ-021 SHALL accept the three events in any order and in any cycle, including all three in the same cycle.
REQ-022 SHALL ignore any data or response whose tag addresses a non-busy slot.
REQ-023 SHALL mark a slot complete once all three flags are set; when the last event arrives in cycle M, output appears at M+1 unless it is blocked by arbitration.
REQ-024 SHALL, when several slots are complete, emit the lowest tag first, one output per cycle.
REQ-025 SHALL take the output word from half 0 if offset<16, else from half 1, at word (offset mod 16).
REQ-026 SHALL apply swap_endianness_data_read to the output word.
REQ-027 SHALL free the slot in the cycle its output is valid; the slot is allocatable from the next cycle, not the same cycle.
REQ-028 SHALL deassert request_ready_out when all MAX_OUTSTANDING slots are busy.
REQ-029 SHALL, when enabled_in is low, block new acceptance while in-flight slots continue to complete.
REQ-030 SHALL drive edge_data_variable_out.valid high for one cycle per completed request.

Reset
REQ-031 SHALL, while rstn_in is low at a clock edge, free all slots, clear all flags, drive every output valid to 0, drive every payload to 0, and drive request_ready_out to 0.
REQ-032 SHALL, on reset mid-operation, abandon in-flight requests; late responses and data for them are ignored per REQ-022.
REQ-033 SHALL assert request_ready_out no earlier than the second cycle after rstn_in rises, and only when enabled_in is high.

Configuration
REQ-034 SHALL, when macro CU_VERTEX_READ_REQUESTER_ERROR_COUNT_EN is defined, add output error_count_out (32 bits, reset 0, saturating).
REQ-035 SHALL, with that macro defined, increment error_count_out for each response whose code is not DONE, and free that slot without any output.
REQ-036 SHALL, without that macro, not have the port, ignore the response code, and treat every response as DONE.

Verification
REQ-037 SHALL cover this scenario: base 0x1000, index 5 -> command address 0x1000, tag 0; data_0 word 5 = 0x11223344 -> output 0x44332211.
REQ-038 SHALL cover this scenario: index 40 (offset 8 within line 0x1080) -> data from half 0, word 8; index 20 -> half 1, word 4.
REQ-039 SHALL cover this scenario: issue 8 requests back-to-back -> ready low after the 8th; complete tag 3 -> ready high one cycle after the tag 3 output.
REQ-040 SHALL cover this scenario: tags 2 and 6 complete in the same cycle -> tag 2 output at M+1, tag 6 output at M+2.
REQ-041 SHALL cover this scenario: response before data_1, then data_1 arrives -> output the cycle after data_1; a stray tag-5 response with slot 5 free -> no output.
REQ-042 SHALL cover this scenario: reset asserted with 4 in flight, then late data and response for those tags -> no output, all slots free; with the macro, a FAILED response -> error_count_out=1 and no output.
